plode_delay_tdc: RTL

//  Parametrised successor to the fixed 100-stage plode delay chain: STAGES-deep chain of singlepath_plode cells

---
 rtl/plode_tdc_pkg.sv | 24 ++
 rtl/plode_popcount.sv | 19 +
 rtl/singlepath_plode.sv | 12 +
 rtl/plode_delay_tdc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/plode_tdc_pkg.sv
// Shared definitions for the plode delay-chain TDC.
//   state_t : controller states
//   clog2   : ceiling log2, never less than 1 (usable for counter widths)
package plode_tdc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    SAMPLE = 3'd2,
    SYNC   = 3'd3,
    DECODE = 3'd4,
    GUARD  = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/plode_popcount.sv
// Combinational ones-count of a WIDTH-bit vector.
//   bits : input vector
//   cnt  : number of bits set, OUT_W wide (default holds 0..WIDTH)
module plode_popcount
  import plode_tdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + OUT_W'(bits[i]);
  end

endmodule

// File: rtl/singlepath_plode.sv
// One delay cell of the plode chain. Logically a buffer; the useful
// property is the physical propagation delay of the placed cell.
//   a : cell input (previous stage or launch flop)
//   y : cell output (next stage and tap)
module singlepath_plode (
  input  logic a,
  output logic y
);

  assign y = a;

endmodule

// File: rtl/plode_delay_tdc.sv
// plode_delay_tdc: STAGES-deep singlepath_plode chain with a launch/capture
// controller. Each measurement toggles the chain input, captures the taps one
// clk later, and counts how many stages the edge crossed. 2^SAMPLES_LOG2
// measurements are summed and the truncated average is reported.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   start          run request, only honoured in IDLE
//   busy           high from the first LAUNCH through DONE
//   result_valid   one-cycle pulse while in DONE
//   result         averaged stage count (acc >> SAMPLES_LOG2)
//   sat            some sample in the run saw every stage flipped
//   out            last chain stage, for external probing
//   min_cnt/max_cnt  per-run extremes (only with PLODE_TDC_MINMAX_EN)
//
// Build option: define PLODE_TDC_MINMAX_EN to add min_cnt/max_cnt.
module plode_delay_tdc
  import plode_tdc_pkg::*;
#(
  parameter  int STAGES       = 100,
  parameter  int SAMPLES_LOG2 = 4,
  parameter  int GUARD_CYC    = 2,
  localparam int CNT_W        = clog2(STAGES + 1),
  localparam int ACC_W        = CNT_W + SAMPLES_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             sat,
  output logic             out
`ifdef PLODE_TDC_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt
`endif
);

  localparam int SMP_W = SAMPLES_LOG2 + 1;
  localparam int GRD_W = clog2(GUARD_CYC + 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((1 << SAMPLES_LOG2) - 1);

  state_t             state, state_nxt;
  logic               launch_q;
  logic [STAGES-1:0]  taps;
  logic [STAGES-1:0]  tap_q;
  logic [STAGES-1:0]  tap_s;
  logic [STAGES-1:0]  match;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_full;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [SMP_W-1:0]   sample_cnt;
  logic [GRD_W-1:0]   guard_cnt;
  logic               sat_run;
  logic               last_smp;

  // Delay chain: each stage output is its own kept net so the cells are not
  // merged into a single buffer.
  for (genvar i = 0; i < STAGES; i++) begin : g_chain
    (* keep = 1 *) logic y;
    if (i == 0) begin : g_first
      singlepath_plode u_cell (.a(launch_q), .y(y));
    end else begin : g_next
      singlepath_plode u_cell (.a(g_chain[i-1].y), .y(y));
    end
    assign taps[i] = y;
  end

  assign out = taps[STAGES-1];

  // Stages that already carry the launched level match launch_q; counting
  // matches works for either edge polarity and ignores bubbles.
  assign match    = ~(tap_s ^ {STAGES{launch_q}});
  assign cnt_full = (cnt == CNT_W'(STAGES));
  assign acc_nxt  = acc + ACC_W'(cnt);
  assign last_smp = (sample_cnt == LAST_SMP);

  plode_popcount #(
    .WIDTH (STAGES),
    .OUT_W (CNT_W)
  ) u_pop (
    .bits (match),
    .cnt  (cnt)
  );

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SYNC;
      SYNC:    state_nxt = DECODE;
      DECODE: begin
        if (last_smp)            state_nxt = DONE;
        else if (GUARD_CYC == 0) state_nxt = LAUNCH;
        else                     state_nxt = GUARD;
      end
      GUARD:   if (guard_cnt == GRD_W'(GUARD_CYC - 1)) state_nxt = LAUNCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SAMPLE -> SYNC boundary: raw capture of the asynchronous taps, then a
  // second flop before any logic looks at them.
  always_ff @(posedge clk) begin
    if (state == SAMPLE) tap_q <= taps;
    if (state == SYNC)   tap_s <= tap_q;
  end

  // DECODE boundary: accumulate; the last sample also registers the result
  // so it is already stable during the DONE pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      launch_q   <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
      guard_cnt  <= '0;
      sat_run    <= 1'b0;
      result     <= '0;
      sat        <= 1'b0;
    end else begin
      unique case (state)
        LAUNCH: launch_q <= ~launch_q;
        DECODE: begin
          acc        <= acc_nxt;
          sat_run    <= sat_run | cnt_full;
          sample_cnt <= sample_cnt + SMP_W'(1);
          guard_cnt  <= '0;
          if (last_smp) begin
            result <= acc_nxt[ACC_W-1:SAMPLES_LOG2];
            sat    <= sat_run | cnt_full;
          end
        end
        GUARD: guard_cnt <= guard_cnt + GRD_W'(1);
        DONE: begin
          acc        <= '0;
          sample_cnt <= '0;
          sat_run    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef PLODE_TDC_MINMAX_EN
  logic [CNT_W-1:0] min_run, max_run, min_nxt, max_nxt;

  assign min_nxt = (cnt < min_run) ? cnt : min_run;
  assign max_nxt = (cnt > max_run) ? cnt : max_run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_cnt <= '0;
      max_cnt <= '0;
    end else if (state == DECODE && last_smp) begin
      min_cnt <= min_nxt;
      max_cnt <= max_nxt;
    end
  end

  // Running extremes restart at the first LAUNCH of every run.
  always_ff @(posedge clk) begin
    if (state == LAUNCH && sample_cnt == '0) begin
      min_run <= CNT_W'(STAGES);
      max_run <= '0;
    end else if (state == DECODE) begin
      min_run <= min_nxt;
      max_run <= max_nxt;
    end
  end
`endif

endmodule
